fir_error_monitor: RTL

- Streaming hardware error-statistics unit that sits directly downstream of the approximate and accurate FIR datapaths.
- Consumes one paired sample per handshake: the approximate output and the accurate output for the same input window.
- Accumulates signed error sum, absolute accurate-result sum, and two error-rate counters over a programmable number of samples.
- Raises done so software can derive mean, ER0, ER1 and mean result without a simulation-only bench.

---
 rtl/fir_error_monitor.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fir_error_monitor.sv
// Purpose : error statistics between paired approximate/accurate FIR samples.
// Latency : 2 cycles from an accepted sample to the accumulators; done follows 3 cycles after the last accept.
// Backpr. : in_ready is high only in RUN while fewer than test_size samples have been taken.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, test_size         run start pulse (IDLE/DONE only) and sample count latched with it
//   in_valid, in_ready       sample handshake for the appr/accu pair
//   appr, accu               signed approximate and accurate FIR outputs
//   busy, done               RUN/DRAIN indicator, result-ready indicator
//   sample_cnt               samples accepted in the current run
//   err_sum, abs_res_sum     signed sum of (appr-accu), unsigned sum of |accu|
//   er0_cnt, er1_cnt         full-word and upper-field (bits >= ER_THRESH) mismatch counts
//   sq_err_sum               saturating sum of (appr-accu)^2, present only with FIR_ERR_SQ_EN
//
// Build option: define FIR_ERR_SQ_EN to add the squared-error accumulator and its port.
module fir_error_monitor #(
  parameter int DATA_WIDTH = 32,
  parameter int ER_THRESH  = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int ACC_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  test_size,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] appr,
  input  logic [DATA_WIDTH-1:0] accu,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sample_cnt,
  output logic [ACC_WIDTH-1:0]  err_sum,
  output logic [ACC_WIDTH-1:0]  abs_res_sum,
  output logic [CNT_WIDTH-1:0]  er0_cnt,
  output logic [CNT_WIDTH-1:0]  er1_cnt
`ifdef FIR_ERR_SQ_EN
  ,
  output logic [ACC_WIDTH-1:0]  sq_err_sum
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Stage-1 register contents for one sample pair.
  typedef struct packed {
    logic [DATA_WIDTH:0] diff;  // appr - accu, exact in DATA_WIDTH+1 bits
    logic [DATA_WIDTH:0] absv;  // |accu|, unsigned, holds 2^(DATA_WIDTH-1)
    logic                ne0;
    logic                ne1;
  } s1_t;

  state_t              state_q, state_d;
  logic [CNT_WIDTH-1:0] size_q;
  logic                start_ok;
  logic                accept;
  logic                drain_first;
  logic                s1_vld;
  s1_t                 s1_q, s1_d;
  logic [DATA_WIDTH:0] accu_x;

  // ---------------- control FSM ----------------
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          start_ok = 1'b1;
          state_d  = (test_size == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = (sample_cnt < size_q);
        accept   = in_valid & in_ready;
        if (accept && (sample_cnt == size_q - CNT_WIDTH'(1)))
          state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // DRAIN always spans two cycles; by the second one stage 1 has
        // emptied into the accumulators, so the results are final.
        if (!drain_first && !s1_vld)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- stage 1 combinational ----------------
  always_comb begin
    accu_x     = {accu[DATA_WIDTH-1], accu};
    s1_d.diff  = {appr[DATA_WIDTH-1], appr} - accu_x;
    s1_d.absv  = accu_x[DATA_WIDTH] ? -accu_x : accu_x;
    s1_d.ne0   = (appr != accu);
    s1_d.ne1   = (appr[DATA_WIDTH-1:ER_THRESH] != accu[DATA_WIDTH-1:ER_THRESH]);
  end

  // ---------------- state, stage 1, stage 2 ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      size_q      <= '0;
      sample_cnt  <= '0;
      drain_first <= 1'b0;
      s1_vld      <= 1'b0;
      s1_q        <= '0;
      err_sum     <= '0;
      abs_res_sum <= '0;
      er0_cnt     <= '0;
      er1_cnt     <= '0;
    end else begin
      state_q     <= state_d;
      drain_first <= (state_d == DRAIN) && (state_q != DRAIN);
      s1_vld      <= accept;
      if (accept)
        s1_q <= s1_d;
      if (start_ok) begin
        size_q      <= test_size;
        sample_cnt  <= '0;
        err_sum     <= '0;
        abs_res_sum <= '0;
        er0_cnt     <= '0;
        er1_cnt     <= '0;
      end else begin
        if (accept)
          sample_cnt <= sample_cnt + CNT_WIDTH'(1);
        if (s1_vld) begin
          err_sum     <= err_sum + {{(ACC_WIDTH-DATA_WIDTH-1){s1_q.diff[DATA_WIDTH]}}, s1_q.diff};
          abs_res_sum <= abs_res_sum + {{(ACC_WIDTH-DATA_WIDTH-1){1'b0}}, s1_q.absv};
          er0_cnt     <= er0_cnt + CNT_WIDTH'(s1_q.ne0);
          er1_cnt     <= er1_cnt + CNT_WIDTH'(s1_q.ne1);
        end
      end
    end
  end

`ifdef FIR_ERR_SQ_EN
  localparam int SQ_W  = 2*DATA_WIDTH + 2;
  localparam int SUM_W = ((SQ_W > ACC_WIDTH) ? SQ_W : ACC_WIDTH) + 1;

  logic [SQ_W-1:0]      diff_w;
  logic [SQ_W-1:0]      sq;
  logic [SUM_W-1:0]     sq_sum;
  logic [ACC_WIDTH-1:0] sq_next;

  // Squaring the sign-extended value modulo 2^SQ_W gives the exact
  // (non-negative) square, since it always fits in SQ_W bits.
  always_comb begin
    diff_w  = {{(SQ_W-DATA_WIDTH-1){s1_q.diff[DATA_WIDTH]}}, s1_q.diff};
    sq      = diff_w * diff_w;
    sq_sum  = SUM_W'(sq_err_sum) + SUM_W'(sq);
    sq_next = sq_sum[ACC_WIDTH-1:0];
    if (sq_sum > SUM_W'({ACC_WIDTH{1'b1}}))
      sq_next = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sq_err_sum <= '0;
    else if (start_ok)
      sq_err_sum <= '0;
    else if (s1_vld)
      sq_err_sum <= sq_next;
  end
`endif

endmodule
